uart_frame_tx: RTL and testbench
================================

UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter NBYTES, default 4: maximum payload bytes per frame (1..16).
REQ-002 Parameter SEP_EN, default 1: when 1, insert a separator character between byte groups.
REQ-003 Parameter SEP_CHAR, default 8'h20: separator character.
REQ-004 Parameter SEP_EVERY, default 2: payload bytes per group (1..NBYTES).
REQ-005 Parameter EOL_EN, default 1: when 1, append CR (8'h0D) then LF (8'h0A) after the payload.
REQ-006 Port clk  in  1: single clock; all logic on its rising edge.
REQ-007 Port rst_n  in  1: asynchronous, active-low reset.
REQ-008 Port start  in  1: frame request, sampled only in IDLE.
REQ-009 Port bcount  in  $clog2(NBYTES+1): payload byte count for the requested frame.
REQ-010 Port tbuf  in  8*NBYTES: payload; byte k = tbuf[8k+7:8k].
REQ-011 Port hex_mode  in  1: 0 = raw bytes; 1 = each byte sent as two uppercase ASCII hex digits.
REQ-012 Port ready  out  1: high only in IDLE.
REQ-013 Port done  out  1: one-cycle pulse after the last character of a frame is accepted.
REQ-014 Port tstart  out  1: one-cycle request to the UART transmitter.
REQ-015 Port tready  in  1: transmitter idle and able to accept a byte.
REQ-016 Port tbus  out  8: character to transmit; registered.

Function
REQ-017 States SHALL be IDLE, ISSUE, GUARD, WAIT and DONE.
REQ-018 In IDLE, start=1 with bcount!=0 SHALL capture tbuf, hex_mode and min(bcount,NBYTES) into internal registers and move to WAIT; bcount=0 SHALL be ignored.
REQ-019 Payload SHALL be sent most-significant byte first: byte bcount-1 down to byte 0.
REQ-020 In hex mode, the high nibble SHALL be sent first; digits map 0-9 to 8'h30-8'h39 and A-F to 8'h41-8'h46.
REQ-021 With SEP_EN=1, SEP_CHAR SHALL be sent after every SEP_EVERY payload bytes, but never after the final payload byte.
REQ-022 With EOL_EN=1, CR and then LF SHALL follow the payload.
REQ-023 Characters per frame SHALL equal bcount*(hex?2:1) + (SEP_EN ? (bcount-1)/SEP_EVERY : 0) + (EOL_EN ? 2 : 0).
REQ-024 WAIT: when tready=1, load the next character into tbus and go to ISSUE.
REQ-025 ISSUE: assert tstart for exactly one cycle and go to GUARD.
REQ-026 tbus SHALL stay stable from ISSUE until the next character load.
REQ-027 GUARD: ignore tready for one cycle, then go to WAIT, or to DONE if the character just issued was the last.
REQ-028 DONE: wait for tready=1, pulse done for one cycle, then return to IDLE.
REQ-029 A start that arrives outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-030 Changes on tbuf, bcount or hex_mode during a frame SHALL NOT affect that frame.
REQ-031 If tready stays low, the block SHALL stall indefinitely in WAIT or DONE with no tstart.
REQ-032 Back-to-back frames: start asserted in the first IDLE cycle after done SHALL be accepted.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE and set tstart=0, done=0, tbus=8'h00 and all counters and captured registers to 0; ready=1.
REQ-034 Reset mid-frame SHALL abort the frame with no further tstart, and SHALL NOT produce a done pulse.

Structure
REQ-035 Package uart_frame_pkg SHALL hold the ASCII constants (CR, LF, SP), the state encoding and a nibble-to-ASCII function.
REQ-036 Sub-module uart_char_sel SHALL be the combinational selector from (byte index, nibble phase, char kind) to the 8-bit character.
REQ-037 The top module SHALL contain the FSM, byte/nibble/group counters and capture registers.

Verification (NBYTES=4, SEP_EVERY=2, transmitter model deasserts tready for 10 cycles after each tstart)
REQ-038 Raw: tbuf=32'h41424344, bcount=4 -> 8'h41, 8'h42, 8'h20, 8'h43, 8'h44, 8'h0D, 8'h0A, then one done pulse.
REQ-039 Hex: tbuf=32'h00003CA5, bcount=2, hex_mode=1 -> "3", "C", "A", "5", CR, LF (no separator).
REQ-040 bcount=0 with start=1 -> no tstart and ready stays 1; bcount=7 -> clamped to 4 bytes.
REQ-041 start and a new tbuf applied mid-frame -> output frame unchanged, and no second frame follows.
REQ-042 rst_n pulsed low after the 3rd tstart -> tstart=0 and ready=1 immediately, and no done pulse.
REQ-043 tready held low for 500 cycles in WAIT -> no tstart, and tbus holds its value.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the framed UART character sequencer: ASCII constants,
// FSM state encoding, character-kind encoding and the hex digit helper.
package uart_frame_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_GUARD,
    ST_DONE
  } state_t;

  // What the next character on tbus is drawn from.
  typedef enum logic [1:0] {
    CK_PAY,
    CK_SEP,
    CK_CR,
    CK_LF
  } char_kind_t;

  // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase).
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_char_sel.sv
// Combinational character selector: maps (byte index, nibble phase, kind) onto
// the 8-bit character to hand to the transmitter.
module uart_char_sel
  import uart_frame_pkg::*;
#(
  parameter int         NBYTES   = 4,
  parameter logic [7:0] SEP_CHAR = ASCII_SP
) (
  input  logic [8*NBYTES-1:0]          buf_data,
  input  logic [$clog2(NBYTES+1)-1:0]  byte_idx,
  input  logic                         nib_lo,
  input  logic                         hex,
  input  char_kind_t                   kind,
  output logic [7:0]                   ch
);

  localparam int CW = $clog2(NBYTES + 1);

  logic [7:0] sel_byte;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_idx == CW'(k)) sel_byte = buf_data[8*k +: 8];
    end
  end

  always_comb begin
    ch = sel_byte;
    unique case (kind)
      CK_PAY: begin
        if (hex) ch = nib_to_ascii(nib_lo ? sel_byte[3:0] : sel_byte[7:4]);
      end
      CK_SEP:  ch = SEP_CHAR;
      CK_CR:   ch = ASCII_CR;
      CK_LF:   ch = ASCII_LF;
      default: ch = sel_byte;
    endcase
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame sequencer feeding a byte-wide UART transmitter: payload (raw or hex),
// optional group separators and optional CR/LF, one character per handshake.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int         NBYTES    = 4,
  parameter bit         SEP_EN    = 1'b1,
  parameter logic [7:0] SEP_CHAR  = ASCII_SP,
  parameter int         SEP_EVERY = 2,
  parameter bit         EOL_EN    = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(NBYTES+1)-1:0] bcount,
  input  logic [8*NBYTES-1:0]         tbuf,
  input  logic                        hex_mode,
  output logic                        ready,
  output logic                        done,
  output logic                        tstart,
  input  logic                        tready,
  output logic [7:0]                  tbus
);

  localparam int            CW       = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(NBYTES);
  localparam logic [CW-1:0] GRP_LAST = CW'(SEP_EVERY - 1);

  state_t              state, state_nxt;
  logic [8*NBYTES-1:0] cap_buf;
  logic                cap_hex;
  logic [CW-1:0]       byte_idx, byte_idx_nxt;
  logic [CW-1:0]       grp_cnt, grp_cnt_nxt;
  logic                nib_lo, nib_lo_nxt;
  char_kind_t          kind, kind_nxt;
  logic                last_q, last_nxt;
  logic [CW-1:0]       cnt_clamped;
  logic                accept;
  logic                load;
  logic [7:0]          char_cur;

  assign cnt_clamped = (bcount > MAX_CNT) ? MAX_CNT : bcount;
  assign accept      = (state == ST_IDLE) && start && (bcount != '0);
  assign load        = (state == ST_WAIT) && tready;
  assign ready       = (state == ST_IDLE);
  assign tstart      = (state == ST_ISSUE);

  uart_char_sel #(
    .NBYTES   (NBYTES),
    .SEP_CHAR (SEP_CHAR)
  ) u_char_sel (
    .buf_data (cap_buf),
    .byte_idx (byte_idx),
    .nib_lo   (nib_lo),
    .hex      (cap_hex),
    .kind     (kind),
    .ch       (char_cur)
  );

  // Position of the character after the one being loaded now. The final
  // payload byte never takes a separator because the byte_idx==0 test wins.
  always_comb begin
    byte_idx_nxt = byte_idx;
    grp_cnt_nxt  = grp_cnt;
    nib_lo_nxt   = nib_lo;
    kind_nxt     = kind;
    last_nxt     = 1'b0;
    unique case (kind)
      CK_PAY: begin
        if (cap_hex && !nib_lo) begin
          nib_lo_nxt = 1'b1;
        end else begin
          nib_lo_nxt = 1'b0;
          if (byte_idx == '0) begin
            if (EOL_EN) kind_nxt = CK_CR;
            else        last_nxt = 1'b1;
          end else begin
            byte_idx_nxt = byte_idx - 1'b1;
            if (SEP_EN && (grp_cnt == GRP_LAST)) begin
              kind_nxt    = CK_SEP;
              grp_cnt_nxt = '0;
            end else begin
              grp_cnt_nxt = grp_cnt + 1'b1;
            end
          end
        end
      end
      CK_SEP:  kind_nxt = CK_PAY;
      CK_CR:   kind_nxt = CK_LF;
      CK_LF:   last_nxt = 1'b1;
      default: kind_nxt = CK_PAY;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_WAIT;
      ST_WAIT:  if (tready) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_GUARD;
      // The transmitter may not have dropped tready yet; skip one cycle.
      ST_GUARD: state_nxt = last_q ? ST_DONE : ST_WAIT;
      ST_DONE:  if (tready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is assigned with <= so every flop samples pre-edge values;
  // blocking assignments here would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the payload capture register is reset along with everything else so
  // a fresh frame never shows stale data; it is flop-based, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_buf  <= '0;
      cap_hex  <= 1'b0;
      byte_idx <= '0;
      grp_cnt  <= '0;
      nib_lo   <= 1'b0;
      kind     <= CK_PAY;
      last_q   <= 1'b0;
      tbus     <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= (state == ST_DONE) && tready;
      if (accept) begin
        cap_buf  <= tbuf;
        cap_hex  <= hex_mode;
        byte_idx <= cnt_clamped - 1'b1;
        grp_cnt  <= '0;
        nib_lo   <= 1'b0;
        kind     <= CK_PAY;
        last_q   <= 1'b0;
      end else if (load) begin
        tbus     <= char_cur;
        byte_idx <= byte_idx_nxt;
        grp_cnt  <= grp_cnt_nxt;
        nib_lo   <= nib_lo_nxt;
        kind     <= kind_nxt;
        last_q   <= last_nxt;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: queue-based frame model, per-cycle
// compare process, busy-for-10-cycles transmitter model, randomized frames.
module tb_uart_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  bcount;
  logic [31:0] tbuf;
  logic        hex_mode;
  logic        ready;
  logic        done;
  logic        tstart;
  logic        tready;
  logic [7:0]  tbus;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tmp_q[$];
  bit         outstanding = 1'b0;
  bit         hold_low    = 1'b0;
  int         tstart_cnt  = 0;
  int         busy        = 0;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .NBYTES    (4),
    .SEP_EN    (1'b1),
    .SEP_CHAR  (8'h20),
    .SEP_EVERY (2),
    .EOL_EN    (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bcount   (bcount),
    .tbuf     (tbuf),
    .hex_mode (hex_mode),
    .ready    (ready),
    .done     (done),
    .tstart   (tstart),
    .tready   (tready),
    .tbus     (tbus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected characters of one frame, straight from the framing rules.
  function automatic void build(input logic [31:0] b, input int cnt, input bit hex);
    string      hx = "0123456789ABCDEF";
    int         n;
    logic [7:0] v;
    n = (cnt > 4) ? 4 : cnt;
    tmp_q.delete();
    for (int i = n - 1; i >= 0; i--) begin
      v = b[8*i +: 8];
      if (hex) begin
        tmp_q.push_back(hx[v[7:4]]);
        tmp_q.push_back(hx[v[3:0]]);
      end else begin
        tmp_q.push_back(v);
      end
      if (i != 0 && ((n - i) % 2) == 0) tmp_q.push_back(8'h20);
    end
    if (n > 0) begin
      tmp_q.push_back(8'h0D);
      tmp_q.push_back(8'h0A);
    end
  endfunction

  // Transmitter model: busy for 10 cycles after each tstart, or held low.
  initial begin : xmit_model
    tready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n)      busy = 0;
      else if (tstart) busy = 10;
      else if (busy > 0) busy--;
      tready = (busy == 0) && !hold_low;
    end
  end

  initial begin : compare
    logic [7:0] prev_tbus   = 8'h00;
    logic       prev_tstart = 1'b0;
    logic       prev_rst    = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_expected", {31'b0, outstanding}, 32'd1);
        check("done_chars_left", exp_q.size(), 32'd0);
        outstanding = 1'b0;
      end
      if (tstart) begin
        tstart_cnt++;
        check("tstart_width", {31'b0, prev_tstart}, 32'd0);
        if (exp_q.size() == 0) check("tstart_expected", 32'd0, 32'd1);
        else                   check("char", {24'b0, tbus}, {24'b0, exp_q.pop_front()});
      end else if (rst_n && prev_rst) begin
        check("tbus_hold", {24'b0, tbus}, {24'b0, prev_tbus});
      end
      check("ready", {31'b0, ready}, outstanding ? 32'd0 : 32'd1);
      prev_tbus   = tbus;
      prev_tstart = tstart;
      prev_rst    = rst_n;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] b, input int cnt, input bit hex);
    int n;
    check("ready_before_start", {31'b0, ready}, 32'd1);
    tbuf     = b;
    bcount   = cnt[2:0];
    hex_mode = hex;
    start    = 1'b1;
    if (cnt != 0) begin
      build(b, cnt, hex);
      n = (cnt > 4) ? 4 : cnt;
      check("frame_len", tmp_q.size(), n * (hex ? 2 : 1) + (n - 1) / 2 + 2);
      foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
      outstanding = 1'b1;
    end
    tick();
    start    = 1'b0;
    tbuf     = $urandom;
    bcount   = 3'($urandom_range(0, 7));
    hex_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      if (!outstanding) return;
      tick();
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_tstarts(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (tstart_cnt >= target) return;
      tick();
    end
    check("tstart_timeout", 32'd0, 32'd1);
  endtask

  initial begin : stimulus
    logic [7:0] lit_raw[7] = '{8'h41, 8'h42, 8'h20, 8'h43, 8'h44, 8'h0D, 8'h0A};
    logic [7:0] lit_hex[6] = '{8'h33, 8'h43, 8'h41, 8'h35, 8'h0D, 8'h0A};
    logic [7:0] lit_clp[7] = '{8'hDE, 8'hAD, 8'h20, 8'hBE, 8'hEF, 8'h0D, 8'h0A};
    logic [7:0] held;
    int         base;

    rst_n = 1'b0; start = 1'b0; bcount = '0; tbuf = '0; hex_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",  {31'b0, ready},  32'd1);
    check("rst_tstart", {31'b0, tstart}, 32'd0);
    check("rst_done",   {31'b0, done},   32'd0);
    check("rst_tbus",   {24'b0, tbus},   32'd0);
    #1 rst_n = 1'b1;
    tick();

    // Pin the model against hand-derived frames.
    build(32'h41424344, 4, 1'b0);
    check("model_raw_len", tmp_q.size(), 32'd7);
    foreach (lit_raw[i]) check("model_raw", {24'b0, tmp_q[i]}, {24'b0, lit_raw[i]});
    build(32'h00003CA5, 2, 1'b1);
    check("model_hex_len", tmp_q.size(), 32'd6);
    foreach (lit_hex[i]) check("model_hex", {24'b0, tmp_q[i]}, {24'b0, lit_hex[i]});
    build(32'hDEADBEEF, 7, 1'b0);
    check("model_clamp_len", tmp_q.size(), 32'd7);
    foreach (lit_clp[i]) check("model_clamp", {24'b0, tmp_q[i]}, {24'b0, lit_clp[i]});

    // Directed frames: raw, hex, clamp.
    send(32'h41424344, 4, 1'b0); wait_idle();
    send(32'h00003CA5, 2, 1'b1); wait_idle();
    send(32'hDEADBEEF, 7, 1'b0); wait_idle();

    // bcount=0 is ignored: no tstart, ready stays high.
    send(32'h12345678, 0, 1'b0);
    repeat (30) tick();

    // Start and new inputs mid-frame are neither applied nor queued.
    send(32'hCAFE0102, 4, 1'b1);
    repeat (15) tick();
    start = 1'b1; tbuf = 32'h55AA55AA; bcount = 3'd3; hex_mode = 1'b0;
    repeat (5) tick();
    start = 1'b0;
    wait_idle();
    repeat (60) tick();

    // Reset right after the third tstart aborts the frame with no done.
    base = tstart_cnt;
    send(32'h31323334, 4, 1'b0);
    wait_tstarts(base + 3);
    rst_n = 1'b0;
    #1;
    check("abort_tstart", {31'b0, tstart}, 32'd0);
    check("abort_ready",  {31'b0, ready},  32'd1);
    check("abort_done",   {31'b0, done},   32'd0);
    exp_q.delete();
    outstanding = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (40) tick();

    // tready held low: stall in WAIT, no tstart, tbus frozen.
    base = tstart_cnt;
    send(32'h9A8B7C6D, 4, 1'b1);
    wait_tstarts(base + 2);
    hold_low = 1'b1;
    held = tbus;
    base = tstart_cnt;
    repeat (500) tick();
    check("stall_no_tstart", tstart_cnt, base);
    check("stall_tbus", {24'b0, tbus}, {24'b0, held});
    hold_low = 1'b0;
    wait_idle();

    // Randomized frames, some issued back-to-back in the first IDLE cycle.
    for (int f = 0; f < 25; f++) begin
      int  cnt;
      bit  hex;
      cnt = $urandom_range(0, 7);
      hex = 1'($urandom_range(0, 1));
      send($urandom, cnt, hex);
      if (cnt == 0) repeat (5) tick();
      else          wait_idle();
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (20) tick();
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
